// File: rtl/ocpi_axis_pkg.sv
// Shared definitions for the OPED AXI4-Stream loopback: mode encodings and
// elaboration-time helpers.
package ocpi_axis_pkg;

    typedef enum logic [1:0] {
        MODE_FWD   = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_DRAIN = 2'd2
    } mode_e;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Encoding 3 is a second FWD code point.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_HOLD;
            2'd2:    return MODE_DRAIN;
            default: return MODE_FWD;
        endcase
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered read port and
// an occupancy output; a written word is visible on rd_data one edge later.
module axis_sync_fifo
    import ocpi_axis_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_en,
    output logic [AW:0]  level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [W-1:0]  rd_data_reg;
    logic          full;
    logic          push;
    logic          pop;

    assign full        = (count_reg == FULL_LEVEL);
    assign rd_valid    = (count_reg != '0);
    assign push        = wr_en & ~full;
    assign pop         = rd_en & rd_valid;
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);
    assign rd_data     = rd_data_reg;
    assign level       = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The head register prefetches the next entry; a write into the slot that
    // becomes the head is bypassed so the first word falls through in one edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        rd_data_reg <= (push && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
    end

endmodule

// File: rtl/axis_loopback_buf.sv
// Buffered OPED egress-to-ingress AXI4-Stream loopback with FWD/HOLD/DRAIN
// modes and frame/drop counters for DMA soak testing.
module axis_loopback_buf
    import ocpi_axis_pkg::*;
#(
    parameter int DW      = 256,
    parameter int DEPTH   = 16,
    parameter int MDEPTH  = 4,
    parameter int LW      = 16,
    parameter int CW      = 32,
    localparam int LVLW   = clog2(DEPTH) + 1
) (
    input  logic            ACLK,
    input  logic            ARESETN,

    input  logic [DW-1:0]   S_AXIS_DAT_TDATA,
    input  logic [DW/8-1:0] S_AXIS_DAT_TSTRB,
    input  logic            S_AXIS_DAT_TLAST,
    input  logic            S_AXIS_DAT_TVALID,
    output logic            S_AXIS_DAT_TREADY,
    input  logic [LW-1:0]   S_AXIS_LEN_TDATA,
    input  logic            S_AXIS_LEN_TVALID,
    output logic            S_AXIS_LEN_TREADY,
    input  logic [7:0]      S_AXIS_SPT_TDATA,
    input  logic            S_AXIS_SPT_TVALID,
    output logic            S_AXIS_SPT_TREADY,
    input  logic [7:0]      S_AXIS_DPT_TDATA,
    input  logic            S_AXIS_DPT_TVALID,
    output logic            S_AXIS_DPT_TREADY,
    input  logic [7:0]      S_AXIS_ERR_TDATA,
    input  logic            S_AXIS_ERR_TVALID,
    output logic            S_AXIS_ERR_TREADY,

    output logic [DW-1:0]   M_AXIS_DAT_TDATA,
    output logic [DW/8-1:0] M_AXIS_DAT_TSTRB,
    output logic            M_AXIS_DAT_TLAST,
    output logic            M_AXIS_DAT_TVALID,
    input  logic            M_AXIS_DAT_TREADY,
    output logic [LW-1:0]   M_AXIS_LEN_TDATA,
    output logic            M_AXIS_LEN_TVALID,
    input  logic            M_AXIS_LEN_TREADY,
    output logic [7:0]      M_AXIS_SPT_TDATA,
    output logic            M_AXIS_SPT_TVALID,
    input  logic            M_AXIS_SPT_TREADY,
    output logic [7:0]      M_AXIS_DPT_TDATA,
    output logic            M_AXIS_DPT_TVALID,
    input  logic            M_AXIS_DPT_TREADY,
    output logic [7:0]      M_AXIS_ERR_TDATA,
    output logic            M_AXIS_ERR_TVALID,
    input  logic            M_AXIS_ERR_TREADY,

    input  logic [1:0]      MODE,
    output logic [CW-1:0]   FRAME_CNT,
    output logic [CW-1:0]   DROP_CNT,
    output logic [LVLW-1:0] DAT_LEVEL
);

    localparam int DATW              = DW + DW/8 + 1;
    localparam int MLVLW             = clog2(MDEPTH) + 1;
    localparam logic [LVLW-1:0] DAT_FULL_LEVEL = LVLW'(DEPTH);

    mode_e           mode_in;
    mode_e           dat_mode_reg;
    mode_e           dat_mode;
    logic            ready_en_reg;
    logic            dat_in_frame_reg;
    logic            dat_hold;
    logic            dat_drain;
    logic            dat_full;
    logic            dat_valid;
    logic            dat_s_hs;
    logic            dat_push;
    logic            dat_m_hs;
    logic [DATW-1:0] dat_rd_data;
    logic [CW-1:0]   frame_cnt_reg;
    logic [CW-1:0]   drop_cnt_reg;

    assign mode_in = decode_mode(MODE);

    // Mid-frame the DAT channel keeps the mode it had when the frame started.
    assign dat_mode  = dat_in_frame_reg ? dat_mode_reg : mode_in;
    assign dat_hold  = (dat_mode == MODE_HOLD);
    assign dat_drain = (dat_mode == MODE_DRAIN);
    assign dat_full  = (DAT_LEVEL == DAT_FULL_LEVEL);

    assign S_AXIS_DAT_TREADY = ready_en_reg & (dat_drain | ~dat_full);
    assign dat_s_hs          = S_AXIS_DAT_TVALID & S_AXIS_DAT_TREADY;
    assign dat_push          = dat_s_hs & ~dat_drain;
    assign M_AXIS_DAT_TVALID = dat_valid & ~dat_hold;
    assign dat_m_hs          = M_AXIS_DAT_TVALID & M_AXIS_DAT_TREADY;
    assign {M_AXIS_DAT_TLAST, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TDATA} = dat_rd_data;

    axis_sync_fifo #(
        .W     (DATW),
        .DEPTH (DEPTH)
    ) u_dat_fifo (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .wr_data  ({S_AXIS_DAT_TLAST, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TDATA}),
        .wr_en    (dat_push),
        .rd_data  (dat_rd_data),
        .rd_valid (dat_valid),
        .rd_en    (dat_m_hs),
        .level    (DAT_LEVEL)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_reg     <= 1'b0;
            dat_in_frame_reg <= 1'b0;
            dat_mode_reg     <= MODE_FWD;
            frame_cnt_reg    <= '0;
            drop_cnt_reg     <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            dat_mode_reg <= dat_mode;
            if (dat_s_hs) begin
                dat_in_frame_reg <= ~S_AXIS_DAT_TLAST;
            end
            if (dat_m_hs && M_AXIS_DAT_TLAST) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            if (dat_s_hs && dat_drain && S_AXIS_DAT_TLAST) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign FRAME_CNT = frame_cnt_reg;
    assign DROP_CNT  = drop_cnt_reg;

    // Metadata channels: index 0 = LEN, 1 = SPT, 2 = DPT, 3 = ERR.
    logic [3:0] meta_s_valid;
    logic [3:0] meta_s_ready;
    logic [3:0] meta_m_valid;
    logic [3:0] meta_m_ready;
    logic [3:0] meta_valid;
    logic [3:0] meta_push;
    logic [3:0] meta_pop;
    logic [7:0] byte_s_data [1:3];
    logic [7:0] byte_m_data [1:3];
    logic       meta_hold;
    logic       meta_drain;

    assign meta_hold  = (mode_in == MODE_HOLD);
    assign meta_drain = (mode_in == MODE_DRAIN);

    assign meta_s_valid = {S_AXIS_ERR_TVALID, S_AXIS_DPT_TVALID, S_AXIS_SPT_TVALID, S_AXIS_LEN_TVALID};
    assign meta_m_ready = {M_AXIS_ERR_TREADY, M_AXIS_DPT_TREADY, M_AXIS_SPT_TREADY, M_AXIS_LEN_TREADY};
    assign {S_AXIS_ERR_TREADY, S_AXIS_DPT_TREADY, S_AXIS_SPT_TREADY, S_AXIS_LEN_TREADY} = meta_s_ready;
    assign {M_AXIS_ERR_TVALID, M_AXIS_DPT_TVALID, M_AXIS_SPT_TVALID, M_AXIS_LEN_TVALID} = meta_m_valid;

    assign byte_s_data[1] = S_AXIS_SPT_TDATA;
    assign byte_s_data[2] = S_AXIS_DPT_TDATA;
    assign byte_s_data[3] = S_AXIS_ERR_TDATA;
    assign M_AXIS_SPT_TDATA = byte_m_data[1];
    assign M_AXIS_DPT_TDATA = byte_m_data[2];
    assign M_AXIS_ERR_TDATA = byte_m_data[3];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_meta
            localparam logic [MLVLW-1:0] META_FULL_LEVEL = MLVLW'(MDEPTH);
            logic [MLVLW-1:0] level;
            logic             full;

            assign full              = (level == META_FULL_LEVEL);
            assign meta_s_ready[gi]  = ready_en_reg & (meta_drain | ~full);
            assign meta_push[gi]     = meta_s_valid[gi] & meta_s_ready[gi] & ~meta_drain;
            assign meta_m_valid[gi]  = meta_valid[gi] & ~meta_hold;
            assign meta_pop[gi]      = meta_m_valid[gi] & meta_m_ready[gi];

            if (gi == 0) begin : g_len
                axis_sync_fifo #(
                    .W     (LW),
                    .DEPTH (MDEPTH)
                ) u_fifo (
                    .clk      (ACLK),
                    .rst_n    (ARESETN),
                    .wr_data  (S_AXIS_LEN_TDATA),
                    .wr_en    (meta_push[gi]),
                    .rd_data  (M_AXIS_LEN_TDATA),
                    .rd_valid (meta_valid[gi]),
                    .rd_en    (meta_pop[gi]),
                    .level    (level)
                );
            end else begin : g_byte
                axis_sync_fifo #(
                    .W     (8),
                    .DEPTH (MDEPTH)
                ) u_fifo (
                    .clk      (ACLK),
                    .rst_n    (ARESETN),
                    .wr_data  (byte_s_data[gi]),
                    .wr_en    (meta_push[gi]),
                    .rd_data  (byte_m_data[gi]),
                    .rd_valid (meta_valid[gi]),
                    .rd_en    (meta_pop[gi]),
                    .level    (level)
                );
            end
        end
    endgenerate

endmodule
